pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard and stall controller for the five-stage pipeline. It generates per-register enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, the operand forwarding selects and the PC redirect strobe. It also sequences data-memory waits through a small FSM with a timeout. The block sits beside the datapath and drives the enable/flush inputs of every pipeline register and the PC.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before the error state (1..65535).
- CNT_W, 32: width of the performance counters.

- clkIn  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- idRs1, idRs2  in  5 each  source registers of the instruction in ID.
- idUse1, idUse2  in  1 each  the ID instruction reads rs1/rs2.
- exRd  in  5  destination register in EX.
- exRegWrite, exMemRead  in  1 each  EX instruction writes the regfile / is a load.
- exBrTaken  in  1  branch or jump resolved taken in EX.
- memRd  in  5  destination register in MEM.
- memRegWrite  in  1  MEM instruction writes the regfile.
- memReq  in  1  MEM stage has a data-memory access this cycle.
- memReady  in  1  data memory completes the access this cycle.
- wbRd  in  5  destination register in WB.
- wbRegWrite  in  1  WB instruction writes the regfile.
- pcEn, ifidEn, idexEn, exmemEn, memwbEn  out  1 each  register load enables.
- ifidFlush, idexFlush, memwbFlush  out  1 each  load a bubble (all-zero controls) instead of the input.
- pcRedirect  out  1  PC loads the branch target.
- fwdA, fwdB  out  2 each  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- memErr  out  1  sticky memory-timeout error.
- stallCnt, flushCnt  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. The reset state is RUN.
- RUN with memReq=1 and memReady=0:
  - Same cycle: all enables are 0 and memwbFlush=1.
  - Next state is MEM_WAIT and waitCnt is loaded with 1.
- MEM_WAIT with memReady=0:
  - Outputs are held as in the RUN stall case.
  - waitCnt increments.
  - When waitCnt reaches MEM_TIMEOUT, the next state is ERROR.
- MEM_WAIT with memReady=1:
  - Same cycle: normal RUN evaluation applies (the pipeline advances).
  - Next state is RUN and waitCnt is cleared.
- ERROR: all enables are 0, memwbFlush=1 and memErr=1. The only exit is reset.
- Load-use hazard (RUN, no memory stall):
  - Condition: exMemRead, exRd≠0, and (idUse1 with idRs1=exRd, or idUse2 with idRs2=exRd).
  - Response: pcEn=0, ifidEn=0, idexFlush=1. All other enables are 1.
- Taken branch (RUN, no memory stall):
  - pcRedirect=1, ifidFlush=1, idexFlush=1.
  - This overrides load-use: the stalled ID instruction is discarded and pcEn=1.
- Priority order: ERROR, then memory stall, then branch, then load-use, then normal (all enables 1, no flushes).
- A branch occurring during a memory stall is not lost. EX is frozen, so exBrTaken stays asserted and the redirect takes effect in the cycle memReady rises.
- Forwarding (combinational, all states), evaluated per operand:
  - Select 10 if memRegWrite, memRd≠0 and memRd equals the source register.
  - Otherwise select 01 if wbRegWrite, wbRd≠0 and wbRd equals the source register.
  - Otherwise select 00.
- x0 is never forwarded and never causes a stall.
- Performance counters (both wrap modulo 2^CNT_W):
  - stallCnt increments in every cycle with pcEn=0.
  - flushCnt increments in every cycle with pcRedirect=1.

## Timing
- All strobe outputs are combinational from the inputs and the current state, so a stall takes effect in the same cycle it is detected.
- State, waitCnt, memErr and the counters are registered.
- While resetn=0, asynchronously:
  - Outputs: all enables 0, ifidFlush=idexFlush=memwbFlush=1, pcRedirect=0, fwd=00, memErr=0.
  - Internal: counters 0, state RUN.
- Reset deasserted mid-wait or in ERROR returns the block to RUN. The pending memory access is abandoned.
- Load-use stall: exactly 1 cycle.
- Branch penalty: 2 bubbles.
- Memory stall length equals the number of cycles with memReq=1 and memReady=0. A zero-wait access costs 0 cycles.
- The ERROR entry edge occurs MEM_TIMEOUT cycles after the first wait cycle. memErr is asserted the following cycle.

## Structure
- A shared package pipe_pkg holds:
  - the FSM state enum;
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the register-index width constant.
- Sub-module hazard_fwd_unit: purely combinational forwarding compare, instantiated once.
- The FSM, stall/flush priority logic and counters live in the top module.

## Test plan
- Load-use: exMemRead=1, exRd=5, idRs1=5, idUse1=1 -> one cycle with pcEn=0, ifidEn=0, idexFlush=1; stallCnt=1.
- Branch and load-use in the same cycle: exBrTaken=1 plus the load-use condition -> pcRedirect=1, ifidFlush=idexFlush=1, pcEn=1; flushCnt=1.
- Memory wait: memReq=1, memReady low for 3 cycles then high -> all enables 0 for 3 cycles, memwbFlush=1; state returns to RUN; stallCnt=3.
- Timeout: MEM_TIMEOUT=4, memReady held 0 -> memErr=1 after the 4-cycle wait; enables stay 0 until resetn pulses low; after reset, memErr=0 and state is RUN.
- Forwarding priority: memRd=wbRd=7, both regwrite, idRs2=7 in EX -> fwdB=10. Then memRd=0 with wbRd=0 -> fwdB=00.
- Asynchronous reset mid-wait: resetn low between clock edges during MEM_WAIT -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline hazard controller: the hazard FSM
// state type, the EX operand forwarding select encodings and the register
// index width used by every pipeline register-number field.
package pipe_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundle between the datapath and the hazard controller.
//   master : datapath side, drives the stage register numbers/flags and
//            the memory handshake, receives enables, flushes, redirect,
//            forwarding selects, the error flag and the counters.
//   slave  : the hazard controller itself.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  import pipe_pkg::*;

  logic [REG_IDX_W-1:0] idRs1, idRs2, exRd, memRd, wbRd;
  logic                 idUse1, idUse2;
  logic                 exRegWrite, exMemRead, exBrTaken;
  logic                 memRegWrite, memReq, memReady;
  logic                 wbRegWrite;

  logic                 pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic                 ifidFlush, idexFlush, memwbFlush;
  logic                 pcRedirect;
  logic [1:0]           fwdA, fwdB;
  logic                 memErr;
  logic [CNT_W-1:0]     stallCnt, flushCnt;

  modport master (
    output idRs1, idRs2, idUse1, idUse2, exRd, exRegWrite, exMemRead,
           exBrTaken, memRd, memRegWrite, memReq, memReady, wbRd, wbRegWrite,
    input  pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
           memwbFlush, pcRedirect, fwdA, fwdB, memErr, stallCnt, flushCnt
  );

  modport slave (
    input  idRs1, idRs2, idUse1, idUse2, exRd, exRegWrite, exMemRead,
           exBrTaken, memRd, memRegWrite, memReq, memReady, wbRd, wbRegWrite,
    output pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
           memwbFlush, pcRedirect, fwdA, fwdB, memErr, stallCnt, flushCnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// hazard_fwd_unit
// Purely combinational operand forwarding compare for the two EX operands.
//   memRd/memRegWrite : producer in EX/MEM (youngest, highest priority)
//   wbRd/wbRegWrite   : producer in MEM/WB
//   rs1/rs2           : source registers of the instruction being fed to EX
//   fwdA/fwdB         : FWD_MEM, FWD_WB or FWD_RF per operand
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] memRd,
  input  logic                 memRegWrite,
  input  logic [REG_IDX_W-1:0] wbRd,
  input  logic                 wbRegWrite,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [1:0]           fwdA,
  output logic [1:0]           fwdB
);

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  function automatic logic [1:0] selectFor(input logic [REG_IDX_W-1:0] src,
                                           input logic [REG_IDX_W-1:0] mRd,
                                           input logic                 mWr,
                                           input logic [REG_IDX_W-1:0] wRd,
                                           input logic                 wWr);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mWr && (mRd != '0) && (mRd == src)) begin
      sel = FWD_MEM;
    end else if (wWr && (wRd != '0) && (wRd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwdA = selectFor(rs1, memRd, memRegWrite, wbRd, wbRegWrite);
    fwdB = selectFor(rs2, memRd, memRegWrite, wbRd, wbRegWrite);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central hazard/stall controller for the five-stage pipeline.
//   clkIn  : pipeline clock, rising edge
//   resetn : asynchronous active-low reset
//   hif    : slave side of pipe_hazard_ctrl_if (stage info in; register
//            enables, flushes, PC redirect, forwarding selects, sticky
//            memory-timeout error and stall/flush counters out)
// Strobes are combinational from inputs and state; the FSM, wait counter,
// error flag and performance counters are registered.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clkIn,
  input  logic              resetn,
  pipe_hazard_ctrl_if.slave hif
);

  localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);

  hazard_state_t    state, nextState;
  logic [15:0]      waitCnt, waitNext;
  logic             memErrQ;
  logic [CNT_W-1:0] stallCntQ, flushCntQ;
  logic             memStall, loadUse;
  logic [1:0]       fwdARaw, fwdBRaw;

  hazard_fwd_unit uFwd (
    .memRd       (hif.memRd),
    .memRegWrite (hif.memRegWrite),
    .wbRd        (hif.wbRd),
    .wbRegWrite  (hif.wbRegWrite),
    .rs1         (hif.idRs1),
    .rs2         (hif.idRs2),
    .fwdA        (fwdARaw),
    .fwdB        (fwdBRaw)
  );

  // In MEM_WAIT the access is already outstanding, so only memReady matters.
  assign memStall = ((state == RUN) && hif.memReq && !hif.memReady) ||
                    ((state == MEM_WAIT) && !hif.memReady);

  assign loadUse = hif.exMemRead && (hif.exRd != '0) &&
                   ((hif.idUse1 && (hif.idRs1 == hif.exRd)) ||
                    (hif.idUse2 && (hif.idRs2 == hif.exRd)));

  // Strobe priority: reset, error, memory stall, branch, load-use, normal.
  // A branch wins over load-use because the stalled ID instruction is on
  // the wrong path anyway and gets flushed.
  always_comb begin
    hif.pcEn       = 1'b1;
    hif.ifidEn     = 1'b1;
    hif.idexEn     = 1'b1;
    hif.exmemEn    = 1'b1;
    hif.memwbEn    = 1'b1;
    hif.ifidFlush  = 1'b0;
    hif.idexFlush  = 1'b0;
    hif.memwbFlush = 1'b0;
    hif.pcRedirect = 1'b0;
    if (!resetn) begin
      {hif.pcEn, hif.ifidEn, hif.idexEn, hif.exmemEn, hif.memwbEn} = '0;
      hif.ifidFlush  = 1'b1;
      hif.idexFlush  = 1'b1;
      hif.memwbFlush = 1'b1;
    end else if ((state == ERROR) || memStall) begin
      {hif.pcEn, hif.ifidEn, hif.idexEn, hif.exmemEn, hif.memwbEn} = '0;
      hif.memwbFlush = 1'b1;
    end else if (hif.exBrTaken) begin
      hif.pcRedirect = 1'b1;
      hif.ifidFlush  = 1'b1;
      hif.idexFlush  = 1'b1;
    end else if (loadUse) begin
      hif.pcEn      = 1'b0;
      hif.ifidEn    = 1'b0;
      hif.idexFlush = 1'b1;
    end
  end

  // Forwarding is live in every state but is parked on the regfile in reset.
  always_comb begin
    hif.fwdA     = resetn ? fwdARaw : FWD_RF;
    hif.fwdB     = resetn ? fwdBRaw : FWD_RF;
    hif.memErr   = memErrQ;
    hif.stallCnt = stallCntQ;
    hif.flushCnt = flushCntQ;
  end

  // waitCnt counts stall cycles of the current access, including the first
  // one seen in RUN, so ERROR is entered after exactly MEM_TIMEOUT of them.
  always_comb begin
    nextState = state;
    waitNext  = waitCnt;
    case (state)
      RUN: begin
        if (hif.memReq && !hif.memReady) begin
          waitNext  = 16'd1;
          nextState = (TIMEOUT_W <= 16'd1) ? ERROR : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hif.memReady) begin
          waitNext  = '0;
          nextState = RUN;
        end else begin
          waitNext = waitCnt + 16'd1;
          if (waitNext >= TIMEOUT_W) begin
            nextState = ERROR;
          end
        end
      end
      ERROR:   nextState = ERROR;
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clkIn or negedge resetn) begin
    if (!resetn) begin
      state     <= RUN;
      waitCnt   <= '0;
      memErrQ   <= 1'b0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitNext;
      memErrQ <= (nextState == ERROR);
      if (!hif.pcEn) begin
        stallCntQ <= stallCntQ + 1'b1;
      end
      if (hif.pcRedirect) begin
        flushCntQ <= flushCntQ + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed scoreboard bench: each stimulus cycle pushes its hand-computed
// expected strobes into a queue, and a monitor on the falling edge pops and
// compares them against the controller outputs.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_RST  = 3'b111;
  localparam logic [2:0] FL_MEM  = 3'b001;
  localparam logic [2:0] FL_BR   = 3'b110;
  localparam logic [2:0] FL_LU   = 3'b010;

  logic clkIn = 1'b0;
  logic resetn;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clkIn  (clkIn),
    .resetn (resetn),
    .hif    (hif)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic       resetn;
    logic [4:0] idRs1, idRs2, exRd, memRd, wbRd;
    logic       idUse1, idUse2, exRegWrite, exMemRead, exBrTaken;
    logic       memRegWrite, memReq, memReady, wbRegWrite;
  } stim_t;

  typedef struct {
    string       name;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        redir;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        err;
    int unsigned stall;
    int unsigned flush;
  } exp_t;

  stim_t       s;
  exp_t        expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int unsigned stallTally  = 0;
  int unsigned flushTally  = 0;

  task automatic setIdle();
    s = '{default: '0};
    s.resetn = 1'b1;
  endtask

  task automatic driveInputs();
    resetn          = s.resetn;
    hif.idRs1       = s.idRs1;
    hif.idRs2       = s.idRs2;
    hif.idUse1      = s.idUse1;
    hif.idUse2      = s.idUse2;
    hif.exRd        = s.exRd;
    hif.exRegWrite  = s.exRegWrite;
    hif.exMemRead   = s.exMemRead;
    hif.exBrTaken   = s.exBrTaken;
    hif.memRd       = s.memRd;
    hif.memRegWrite = s.memRegWrite;
    hif.memReq      = s.memReq;
    hif.memReady    = s.memReady;
    hif.wbRd        = s.wbRd;
    hif.wbRegWrite  = s.wbRegWrite;
  endtask

  // Counters are registered, so the value seen in a cycle reflects all
  // earlier cycles since reset; the tally is advanced after the push.
  task automatic applyStimulus(input string name, input logic [4:0] en,
                               input logic [2:0] fl, input logic redir,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic err);
    exp_t e;
    @(posedge clkIn);
    #1;
    driveInputs();
    if (!s.resetn) begin
      stallTally = 0;
      flushTally = 0;
    end
    e = '{name, en, fl, redir, fa, fb, err, stallTally, flushTally};
    expQ.push_back(e);
    if (s.resetn) begin
      if (!en[4]) stallTally++;
      if (redir)  flushTally++;
    end
  endtask

  // Drops resetn between clock edges; the monitor samples before the next
  // rising edge, so only the asynchronous path can produce reset values.
  task automatic asyncResetMidCycle();
    exp_t e;
    @(posedge clkIn);
    #2;
    s.resetn = 1'b0;
    resetn   = 1'b0;
    stallTally = 0;
    flushTally = 0;
    e = '{"async_reset", EN_NONE, FL_RST, 1'b0, FWD_RF, FWD_RF, 1'b0, 0, 0};
    expQ.push_back(e);
  endtask

  task automatic compareField(input string vec, input string what,
                              input logic [31:0] act, input logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", vec, what, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField(e.name, "enables", 32'({hif.pcEn, hif.ifidEn, hif.idexEn,
                 hif.exmemEn, hif.memwbEn}), 32'(e.en));
    compareField(e.name, "flushes", 32'({hif.ifidFlush, hif.idexFlush,
                 hif.memwbFlush}), 32'(e.fl));
    compareField(e.name, "pcRedirect", 32'(hif.pcRedirect), 32'(e.redir));
    compareField(e.name, "fwdA", 32'(hif.fwdA), 32'(e.fa));
    compareField(e.name, "fwdB", 32'(hif.fwdB), 32'(e.fb));
    compareField(e.name, "memErr", 32'(hif.memErr), 32'(e.err));
    compareField(e.name, "stallCnt", hif.stallCnt, e.stall);
    compareField(e.name, "flushCnt", hif.flushCnt, e.flush);
  endtask

  initial begin
    forever begin
      @(negedge clkIn);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    setIdle();
    s.resetn = 1'b0;
    driveInputs();

    // Reset with forwarding-triggering inputs: selects must stay on regfile.
    s.memRd = 5'd7; s.memRegWrite = 1'b1; s.idRs1 = 5'd7;
    applyStimulus("reset", EN_NONE, FL_RST, 0, FWD_RF, FWD_RF, 0);
    setIdle();
    applyStimulus("idle0", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);

    // Load-use hazards.
    setIdle(); s.exMemRead = 1; s.exRd = 5; s.idRs1 = 5; s.idUse1 = 1;
    applyStimulus("loaduse_rs1", EN_LU, FL_LU, 0, FWD_RF, FWD_RF, 0);
    setIdle();
    applyStimulus("after_lu", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    setIdle(); s.exMemRead = 1; s.exRd = 0; s.idRs1 = 0; s.idUse1 = 1;
    applyStimulus("lu_x0", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    setIdle(); s.exMemRead = 1; s.exRd = 6; s.idRs2 = 6; s.idUse2 = 0;
    applyStimulus("lu_rs2_unused", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    s.idUse2 = 1;
    applyStimulus("loaduse_rs2", EN_LU, FL_LU, 0, FWD_RF, FWD_RF, 0);
    setIdle(); s.exRegWrite = 1; s.exRd = 6; s.idRs2 = 6; s.idUse2 = 1;
    applyStimulus("alu_no_stall", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);

    // Branch overrides load-use.
    setIdle(); s.exMemRead = 1; s.exRd = 5; s.idRs1 = 5; s.idUse1 = 1;
    s.exBrTaken = 1;
    applyStimulus("branch_lu", EN_ALL, FL_BR, 1, FWD_RF, FWD_RF, 0);
    setIdle();
    applyStimulus("after_br", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);

    // Forwarding priority and x0 guard.
    setIdle(); s.memRd = 7; s.memRegWrite = 1; s.wbRd = 7; s.wbRegWrite = 1;
    s.idRs1 = 3; s.idRs2 = 7;
    applyStimulus("fwd_mem_over_wb", EN_ALL, FL_NONE, 0, FWD_RF, FWD_MEM, 0);
    s.wbRd = 3;
    applyStimulus("fwd_split", EN_ALL, FL_NONE, 0, FWD_WB, FWD_MEM, 0);
    s.memRd = 0; s.wbRd = 0; s.idRs1 = 0; s.idRs2 = 0;
    applyStimulus("fwd_x0", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    setIdle(); s.memRd = 7; s.memRegWrite = 0; s.wbRd = 7; s.wbRegWrite = 1;
    s.idRs2 = 7;
    applyStimulus("fwd_wb_only", EN_ALL, FL_NONE, 0, FWD_RF, FWD_WB, 0);

    // Three-cycle memory wait, then a zero-wait access.
    setIdle(); s.memReq = 1; s.memReady = 0;
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("memwait%0d", i), EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 0);
    s.memReady = 1;
    applyStimulus("mem_ready", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    setIdle();
    applyStimulus("after_mem", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    s.memReq = 1; s.memReady = 1;
    applyStimulus("zero_wait", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);

    // Branch held through a memory stall redirects when memReady rises.
    setIdle(); s.memReq = 1; s.memReady = 0; s.exBrTaken = 1;
    applyStimulus("br_in_wait", EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 0);
    s.memReady = 1;
    applyStimulus("br_on_ready", EN_ALL, FL_BR, 1, FWD_RF, FWD_RF, 0);

    // Timeout: four stalled cycles, then sticky ERROR.
    setIdle(); s.memReq = 1; s.memReady = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++)
      applyStimulus($sformatf("to_wait%0d", i), EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 0);
    applyStimulus("error0", EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 1);
    applyStimulus("error1", EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 1);
    s.memReq = 0; s.memReady = 1;
    applyStimulus("error_sticky", EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 1);

    // Reset pulse clears ERROR.
    setIdle(); s.resetn = 0;
    applyStimulus("reset2", EN_NONE, FL_RST, 0, FWD_RF, FWD_RF, 0);
    setIdle();
    applyStimulus("post_reset", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    s.memReq = 1; s.memReady = 1;
    applyStimulus("post_reset_run", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);

    // Asynchronous reset in the middle of a memory wait.
    setIdle(); s.memReq = 1; s.memReady = 0;
    s.memRd = 9; s.memRegWrite = 1; s.idRs1 = 9;
    applyStimulus("aw_wait0", EN_NONE, FL_MEM, 0, FWD_MEM, FWD_RF, 0);
    applyStimulus("aw_wait1", EN_NONE, FL_MEM, 0, FWD_MEM, FWD_RF, 0);
    asyncResetMidCycle();
    setIdle();
    applyStimulus("aw_release", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    s.memReq = 1; s.memReady = 0;
    applyStimulus("aw_new_wait", EN_NONE, FL_MEM, 0, FWD_RF, FWD_RF, 0);
    s.memReady = 1;
    applyStimulus("aw_ready", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);
    setIdle();
    applyStimulus("aw_final", EN_ALL, FL_NONE, 0, FWD_RF, FWD_RF, 0);

    // Bounded drain of the scoreboard.
    repeat (3) @(posedge clkIn);
    #2;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
